int_ctrl: RTL and testbench

Game Boy interrupt controller: the responder end of the CPU's `interrupts` / `clear_interrupt` handshake and the memory-mapped owner of IF (`0xFF0F`) and IE (`0xFFFF`). It sits beside the CPU on the core memory bus.
- Peripherals raise level requests; the block edge-detects them into IF, masks IF with IE, and presents registered pending lines to the CPU.
- The CPU acknowledges one interrupt per `clear_interrupt` pulse; the block retires the highest-priority presented bit.

---
 rtl/gb_bus_pkg.sv | 22 ++
 rtl/int_prio_onehot.sv | 12 +
 rtl/int_ctrl.sv | 106 ++++++++++
 tb/tb_int_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gb_bus_pkg.sv
// Shared core-bus definitions: register addresses and interrupt source indices
// used by the interrupt controller, timer, PPU and serial blocks.
package gb_bus_pkg;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam int NUM_INT = 5;

  localparam int INT_VBLANK = 0;
  localparam int INT_STAT   = 1;
  localparam int INT_TIMER  = 2;
  localparam int INT_SERIAL = 3;
  localparam int INT_JOYPAD = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_IE   = 2'd2
  } reg_sel_e;

endpackage

// File: rtl/int_prio_onehot.sv
// Lowest-set-bit one-hot selector; bit 0 is highest priority.
module int_prio_onehot #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);

  // Two's complement isolates the lowest set bit.
  assign grant = req & (~req + WIDTH'(1));

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-captures peripheral requests into IF, masks with
// IE, and retires the highest-priority presented bit on each CPU acknowledge.
module int_ctrl
  import gb_bus_pkg::*;
#(
  parameter int NUM_INT = 5
) (
  input  logic               core_clk,
  input  logic               reset,
  input  logic [15:0]        address_bus,
  input  logic [7:0]         data_bus_out,
  input  logic               mem_we,
  output logic [7:0]         rd_data,
  output logic               rd_sel,
  input  logic [NUM_INT-1:0] irq_req,
  output logic [NUM_INT-1:0] interrupts,
  input  logic               clear_interrupt,
  output logic               int_pending
);

  logic [NUM_INT-1:0] if_q;
  logic [NUM_INT-1:0] if_next;
  logic [7:0]         ie_q;
  logic [NUM_INT-1:0] req_prev;
  logic [NUM_INT-1:0] rise;
  logic [NUM_INT-1:0] ack_grant;
  logic [NUM_INT-1:0] ack_mask;
  logic [7:0]         if_read;
  reg_sel_e           sel;
  logic               we_if;
  logic               we_ie;

  assign rise  = irq_req & ~req_prev;
  assign we_if = mem_we && (address_bus == ADDR_IF);
  assign we_ie = mem_we && (address_bus == ADDR_IE);

  // Acknowledge targets what the CPU actually saw, so masked bits are never retired.
  int_prio_onehot #(
    .WIDTH(NUM_INT)
  ) u_prio (
    .req  (interrupts),
    .grant(ack_grant)
  );

  assign ack_mask = clear_interrupt ? ack_grant : '0;

  // A fresh edge is OR'd last so it beats both an acknowledge and a write of 0.
  always_comb begin
    if_next = if_q & ~ack_mask;
    if (we_if) begin
      if_next = data_bus_out[NUM_INT-1:0];
    end
    if_next = if_next | rise;
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      if_q        <= '0;
      ie_q        <= '0;
      req_prev    <= '0;
      interrupts  <= '0;
      int_pending <= 1'b0;
    end else begin
      req_prev    <= irq_req;
      if_q        <= if_next;
      if (we_ie) begin
        ie_q <= data_bus_out;
      end
      interrupts  <= if_q & ie_q[NUM_INT-1:0];
      int_pending <= |(if_q & ie_q[NUM_INT-1:0]);
    end
  end

  // Unimplemented IF bits read back as 1.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_if_read
      if (gi < NUM_INT) begin : g_live
        assign if_read[gi] = if_q[gi];
      end else begin : g_const
        assign if_read[gi] = 1'b1;
      end
    end
  endgenerate

  always_comb begin
    sel = SEL_NONE;
    if (address_bus == ADDR_IF) begin
      sel = SEL_IF;
    end else if (address_bus == ADDR_IE) begin
      sel = SEL_IE;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (sel)
      SEL_IF:  rd_data = if_read;
      SEL_IE:  rd_data = ie_q;
      default: rd_data = 8'h00;
    endcase
  end

  assign rd_sel = (sel != SEL_NONE);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed-vector bench for int_ctrl with hand-computed expected values.
module tb_int_ctrl;

  logic        core_clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address_bus = 16'h0000;
  logic [7:0]  data_bus_out = 8'h00;
  logic        mem_we = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_sel;
  logic [4:0]  irq_req = 5'b0;
  logic [4:0]  interrupts;
  logic        clear_interrupt = 1'b0;
  logic        int_pending;

  int n_vec = 0;
  int n_err = 0;

  int_ctrl #(.NUM_INT(5)) dut (
    .core_clk       (core_clk),
    .reset          (reset),
    .address_bus    (address_bus),
    .data_bus_out   (data_bus_out),
    .mem_we         (mem_we),
    .rd_data        (rd_data),
    .rd_sel         (rd_sel),
    .irq_req        (irq_req),
    .interrupts     (interrupts),
    .clear_interrupt(clear_interrupt),
    .int_pending    (int_pending)
  );

  always #5 core_clk = ~core_clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic reg_wr(input logic [15:0] addr, input logic [7:0] data);
    address_bus  = addr;
    data_bus_out = data;
    mem_we       = 1'b1;
    tick();
    mem_we       = 1'b0;
  endtask

  task automatic reg_rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    address_bus = addr;
    mem_we      = 1'b0;
    #1;
    check_val(tag, {8'h00, rd_data}, {8'h00, exp});
  endtask

  task automatic ack();
    clear_interrupt = 1'b1;
    tick();
    clear_interrupt = 1'b0;
  endtask

  initial begin
    // Reset read-back
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_val("rst_interrupts", {11'b0, interrupts}, 16'h0000);
    check_val("rst_pending", {15'b0, int_pending}, 16'h0000);
    reg_rd("rst_if", 16'hFF0F, 8'hE0);
    check_val("rst_rd_sel_if", {15'b0, rd_sel}, 16'h0001);
    reg_rd("rst_ie", 16'hFFFF, 8'h00);
    reg_rd("unmapped_rd", 16'hFF10, 8'h00);
    check_val("unmapped_sel", {15'b0, rd_sel}, 16'h0000);

    // Edge capture
    reg_wr(16'hFFFF, 8'h1F);
    irq_req = 5'b00100;
    tick();
    reg_rd("edge_if_k1", 16'hFF0F, 8'hE4);
    check_val("edge_int_k1", {11'b0, interrupts}, 16'h0000);
    tick();
    check_val("edge_int_k2", {11'b0, interrupts}, 16'h0004);
    check_val("edge_pending", {15'b0, int_pending}, 16'h0001);
    for (int i = 0; i < 8; i++) tick();
    ack();
    reg_rd("edge_ack_noreset", 16'hFF0F, 8'hE0);
    check_val("edge_int_lag", {11'b0, interrupts}, 16'h0004);
    tick();
    check_val("edge_int_drop", {11'b0, interrupts}, 16'h0000);
    irq_req = 5'b0;
    tick();
    irq_req = 5'b00100;
    tick();
    reg_rd("edge_reassert", 16'hFF0F, 8'hE4);
    irq_req = 5'b0;
    reg_wr(16'hFF0F, 8'h00);
    tick();

    // Priority acknowledge
    reg_wr(16'hFF0F, 8'h19);
    tick();
    check_val("prio_int", {11'b0, interrupts}, 16'h0019);
    ack();
    reg_rd("prio_ack1", 16'hFF0F, 8'hF8);
    tick();
    check_val("prio_int_after1", {11'b0, interrupts}, 16'h0018);
    ack();
    reg_rd("prio_ack2", 16'hFF0F, 8'hF0);
    reg_wr(16'hFF0F, 8'h00);

    // Masking
    reg_wr(16'hFFFF, 8'h02);
    reg_wr(16'hFF0F, 8'h03);
    tick();
    check_val("mask_int", {11'b0, interrupts}, 16'h0002);
    ack();
    reg_rd("mask_ack", 16'hFF0F, 8'hE1);
    reg_wr(16'hFFFF, 8'hE0);
    reg_rd("ie_upper_bits", 16'hFFFF, 8'hE0);
    tick();
    check_val("ie_upper_nomask", {11'b0, interrupts}, 16'h0000);

    // Simultaneous write 0 + ack + rising edge
    reg_wr(16'hFFFF, 8'h1F);
    reg_wr(16'hFF0F, 8'h07);
    tick();
    check_val("sim_int", {11'b0, interrupts}, 16'h0007);
    address_bus     = 16'hFF0F;
    data_bus_out    = 8'h00;
    mem_we          = 1'b1;
    clear_interrupt = 1'b1;
    irq_req         = 5'b01000;
    tick();
    mem_we          = 1'b0;
    clear_interrupt = 1'b0;
    reg_rd("sim_wr_ack_rise", 16'hFF0F, 8'hE8);
    irq_req = 5'b0;
    reg_wr(16'hFF0F, 8'h02);
    tick();
    check_val("sim2_int", {11'b0, interrupts}, 16'h0002);
    irq_req         = 5'b00010;
    clear_interrupt = 1'b1;
    tick();
    clear_interrupt = 1'b0;
    reg_rd("sim_ack_vs_rise", 16'hFF0F, 8'hE2);
    irq_req = 5'b0;
    tick();

    // Reset mid-operation
    reg_wr(16'hFF0F, 8'hFF);
    reg_wr(16'hFFFF, 8'hFF);
    irq_req = 5'h1F;
    tick();
    tick();
    check_val("pre_rst_int", {11'b0, interrupts}, 16'h001F);
    reset = 1'b1;
    clear_interrupt = 1'b1;
    tick();
    clear_interrupt = 1'b0;
    check_val("mid_rst_int", {11'b0, interrupts}, 16'h0000);
    check_val("mid_rst_pending", {15'b0, int_pending}, 16'h0000);
    reg_rd("mid_rst_if", 16'hFF0F, 8'hE0);
    reg_rd("mid_rst_ie", 16'hFFFF, 8'h00);
    reset = 1'b0;
    tick();
    reg_rd("post_rst_if", 16'hFF0F, 8'hFF);
    reg_rd("post_rst_ie", 16'hFFFF, 8'h00);
    tick();
    check_val("post_rst_int", {11'b0, interrupts}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
